apb_reg_initiator: RTL and testbench
====================================

// Module: apb_reg_initiator
// PURPOSE
//  APB requester for the generated register blocks. It takes one register access at a
//  time on a valid/ready request channel and runs the APB SETUP and ACCESS phases on the
//  apbReg interface. It then returns the read data and error status on a valid/ready
//  response channel. Sits between a CPU/test-host port and any *Regs responder (apb_if.dst).
// PARAMETERS
//  TIMEOUT_CYCLES  256  max ACCESS-phase cycles waiting for pready; 0 = timeout disabled
//  TIMEOUT_DATA    32'hBADD_C0DE  rsp_rdata returned on timeout
// PORTS
//  clk           in   1   clock; all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   request accepted when req_valid & req_ready
//  req_write     in   1   1 = write, 0 = read
//  req_addr      in   32  byte address, driven unmodified onto paddr
//  req_wdata     in   32  write data
//  rsp_valid     out  1   response present
//  rsp_ready     in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata     out  32  read data (0 for writes, TIMEOUT_DATA on timeout)
//  rsp_err       out  1   pslverr seen, or timeout
//  rsp_timeout   out  1   no pready within TIMEOUT_CYCLES
//  apbReg        src  -   apb_if.src: paddr[31:0] psel penable pwrite pwdata[31:0] out;
//                         prdata[31:0] pready pslverr in
// BEHAVIOUR
//  Reset: on the cycle after rst is sampled high, the state is IDLE.
//   - psel, penable, pwrite, paddr, pwdata, rsp_* are all 0.
//   - req_ready is 0 while rst is high.
//  Reset mid-transaction aborts it. psel/penable drop on the next edge. No response is issued.
//  FSM:
//   - IDLE: req_ready=1. On accept, register addr/wdata/write and go to SETUP.
//   - SETUP: psel=1, penable=0. Lasts 1 cycle, then go to ACCESS.
//   - ACCESS: psel=1, penable=1. paddr/pwrite/pwdata are held stable. Count cycles.
//       * If pready=1: capture prdata (reads only) and pslverr, drop psel/penable, go to RESP.
//       * Else if the count = TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0): drop psel/penable,
//         set rsp_err=1, rsp_timeout=1, rsp_rdata=TIMEOUT_DATA, go to RESP.
//   - RESP: rsp_valid=1, rsp_* held stable. On rsp_ready go to IDLE with rsp_valid=0.
//  req_ready=0 in SETUP/ACCESS/RESP: one transaction outstanding at a time.
//  No back-to-back bypass: the next SETUP is at least one cycle after RESP completes.
//  Latency, with accept at edge N and pready seen at ACCESS cycle k (k>=0):
//   - psel rises at N+1, penable at N+2, rsp_valid at N+3+k.
//  Timeout counter:
//   - width $clog2(TIMEOUT_CYCLES+1); clears on entry to ACCESS.
//   - saturates; never wraps.
//   - pready in the same cycle the count hits its limit wins: normal response, no timeout.
//  Response fields:
//   - rsp_err = pslverr for normal completions; 1 for timeouts.
//   - On a read with pslverr=1, prdata is still passed through to rsp_rdata.
//   - Writes: rsp_rdata = 0.
//  While idle, paddr/pwdata/pwrite keep the last transaction's values.
//  pready/pslverr/prdata are ignored outside ACCESS.
//  Slaves with APB_READY_1WS=0 (pready in the first ACCESS cycle) and =1 both work unmodified.
// TESTING
//  1) Write 0x50 data 0x7F to a 0-wait slave:
//     psel at N+1, penable at N+2, rsp_valid at N+3; rsp_err=0, rsp_rdata=0.
//  2) Read 0x78 with roA=0x55 from a 1-wait slave:
//     penable held 2 cycles; rsp_rdata=0x55, rsp_valid at N+4.
//  3) Read unmapped 0x7C:
//     slave pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0xBADDC0DE.
//  4) TIMEOUT_CYCLES=16, slave never asserts pready:
//     penable high exactly 16 cycles, then rsp_timeout=1, rsp_err=1, rsp_rdata=TIMEOUT_DATA.
//  5) rsp_ready low for 5 cycles:
//     rsp_* stable, req_ready=0, psel=0; completes on the cycle rsp_ready rises.
//  6) rst=1 during ACCESS:
//     psel/penable=0 next cycle, no rsp_valid; the next request runs normally.

Source files
------------

// File: rtl/apb_reg_initiator.sv
// APB requester: accepts one register access on a valid/ready request channel, runs the
// APB SETUP/ACCESS phases and returns read data and error status on a response channel.
module apb_reg_initiator #(
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hBADD_C0DE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);

   // A zero TIMEOUT_CYCLES disables the timeout; keep the counter at least one bit wide.
   localparam int CW = (TIMEOUT_CYCLES > 32'sd0) ? $clog2(TIMEOUT_CYCLES + 32'sd1) : 32'sd1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 32'sd1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          psel_r, psel_s;
   logic          penable_r, penable_s;
   logic          pwrite_r, pwrite_s;
   logic [31:0]   paddr_r, paddr_s;
   logic [31:0]   pwdata_r, pwdata_s;
   logic          rsp_valid_r, rsp_valid_s;
   logic [31:0]   rsp_rdata_r, rsp_rdata_s;
   logic          rsp_err_r, rsp_err_s;
   logic          rsp_timeout_r, rsp_timeout_s;

   assign req_ready   = (state_r == ST_IDLE) && !rst;
   assign psel        = psel_r;
   assign penable     = penable_r;
   assign pwrite      = pwrite_r;
   assign paddr       = paddr_r;
   assign pwdata      = pwdata_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_rdata   = rsp_rdata_r;
   assign rsp_err     = rsp_err_r;
   assign rsp_timeout = rsp_timeout_r;

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      psel_s        = psel_r;
      penable_s     = penable_r;
      pwrite_s      = pwrite_r;
      paddr_s       = paddr_r;
      pwdata_s      = pwdata_r;
      rsp_valid_s   = rsp_valid_r;
      rsp_rdata_s   = rsp_rdata_r;
      rsp_err_s     = rsp_err_r;
      rsp_timeout_s = rsp_timeout_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               state_s  = ST_SETUP;
               psel_s   = 1'b1;
               paddr_s  = req_addr;
               pwdata_s = req_wdata;
               pwrite_s = req_write;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_s   = ST_ACCESS;
            penable_s = 1'b1;
            cnt_s     = {CW{1'b0}};
         end
         ST_ACCESS: begin
            // pready on the limit cycle still completes normally
            if (pready) begin
               state_s       = ST_RESP;
               psel_s        = 1'b0;
               penable_s     = 1'b0;
               rsp_valid_s   = 1'b1;
               rsp_rdata_s   = pwrite_r ? 32'h0000_0000 : prdata;
               rsp_err_s     = pslverr;
               rsp_timeout_s = 1'b0;
            end else if ((TIMEOUT_CYCLES != 32'sd0) && (cnt_r == CNT_LIMIT)) begin
               state_s       = ST_RESP;
               psel_s        = 1'b0;
               penable_s     = 1'b0;
               rsp_valid_s   = 1'b1;
               rsp_rdata_s   = TIMEOUT_DATA;
               rsp_err_s     = 1'b1;
               rsp_timeout_s = 1'b1;
            end else begin
               cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_s     = ST_IDLE;
               rsp_valid_s = 1'b0;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            psel_s      = 1'b0;
            penable_s   = 1'b0;
            rsp_valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         cnt_r         <= {CW{1'b0}};
         psel_r        <= 1'b0;
         penable_r     <= 1'b0;
         pwrite_r      <= 1'b0;
         paddr_r       <= 32'h0000_0000;
         pwdata_r      <= 32'h0000_0000;
         rsp_valid_r   <= 1'b0;
         rsp_rdata_r   <= 32'h0000_0000;
         rsp_err_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         psel_r        <= psel_s;
         penable_r     <= penable_s;
         pwrite_r      <= pwrite_s;
         paddr_r       <= paddr_s;
         pwdata_r      <= pwdata_s;
         rsp_valid_r   <= rsp_valid_s;
         rsp_rdata_r   <= rsp_rdata_s;
         rsp_err_r     <= rsp_err_s;
         rsp_timeout_r <= rsp_timeout_s;
      end
   end

endmodule

// File: tb/tb_apb_reg_initiator.sv
// Bench for apb_reg_initiator: directed vector table, random transactions against a
// response/latency model, and hand-written reset and backpressure sequences.
module tb_apb_reg_initiator;

   localparam int          TO = 16;
   localparam logic [31:0] TD = 32'hBADD_C0DE;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [31:0] paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;

   // slave configuration
   int          s_wait;
   bit          s_err, s_hang, s_idle_ready;
   logic [31:0] s_rdata;
   int          acc_k;

   int n_pass = 0;
   int n_tot  = 0;

   apb_reg_initiator #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TD)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   // Slave: pready after s_wait ACCESS cycles; junk on the response pins outside ACCESS.
   assign pready  = (psel && penable) ? (!s_hang && (acc_k >= s_wait)) : s_idle_ready;
   assign prdata  = (psel && penable) ? s_rdata : 32'hFFFF_FFFF;
   assign pslverr = (psel && penable) ? s_err : s_idle_ready;

   always @(posedge clk) begin
      if (rst || !(psel && penable) || pready) acc_k <= 0;
      else acc_k <= acc_k + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else n_pass++;
   endtask

   // Expected response from the slave behaviour alone.
   task automatic model(input bit wr, input logic [31:0] srd, input int wt, input bit er,
                        input bit hang, output logic [31:0] e_rd, output bit e_err,
                        output bit e_to, output int e_lat);
      e_to  = hang || (wt >= TO);
      e_rd  = e_to ? TD : (wr ? 32'h0 : srd);
      e_err = e_to | er;
      e_lat = 3 + (e_to ? TO - 1 : wt);
   endtask

   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] srd, input int wt, input bit er, input bit hang,
                         input int rdly, input logic [31:0] e_rd, input bit e_err,
                         input bit e_to, input int e_lat);
      int p_off, e_off, r_off, pen_n;
      logic [31:0] held;
      @(negedge clk);
      s_wait = wt; s_err = er; s_hang = hang; s_rdata = srd;
      s_idle_ready = 1'($urandom_range(0, 1));
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = ~wr;
      p_off = -1; e_off = -1; r_off = -1; pen_n = 0;
      for (int o = 1; o <= 60 && r_off < 0; o++) begin
         if (o > 1) @(negedge clk);
         if (psel && p_off < 0) p_off = o;
         if (penable) pen_n++;
         if (penable && e_off < 0) begin
            e_off = o;
            chk("paddr", paddr, addr);
            chk("pwrite", {31'd0, pwrite}, {31'd0, wr});
            chk("pwdata", pwdata, wdata);
         end
         if (rsp_valid) r_off = o;
      end
      chk("psel_lat", 32'(p_off), 32'd1);
      chk("penable_lat", 32'(e_off), 32'd2);
      chk("rsp_lat", 32'(r_off), 32'(e_lat));
      chk("penable_cycles", 32'(pen_n), 32'(e_lat - 2));
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
      chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e_to});
      held = rsp_rdata;
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, held);
         chk("hold_busy", {30'd0, req_ready, psel}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
      chk("idle_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_paddr", paddr, addr);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] srd;
      int          wt;
      bit          er;
      bit          hang;
      int          rdly;
      logic [31:0] e_rd;
      bit          e_err;
      bit          e_to;
      int          e_lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [31:0] m_rd;
      bit          m_err, m_to, r_wr, r_er, r_hang;
      int          m_lat, r_wt;
      logic [31:0] r_srd;

      vecs[0] = '{1'b1, 32'h50, 32'h7F,   32'h0,    0,  1'b0, 1'b0, 0, 32'h0,    1'b0, 1'b0, 3};
      vecs[1] = '{1'b0, 32'h78, 32'h0,    32'h55,   1,  1'b0, 1'b0, 0, 32'h55,   1'b0, 1'b0, 4};
      vecs[2] = '{1'b0, 32'h7C, 32'h0,    TD,       0,  1'b1, 1'b0, 0, TD,       1'b1, 1'b0, 3};
      vecs[3] = '{1'b0, 32'h10, 32'h0,    32'h1111, 0,  1'b0, 1'b1, 0, TD,       1'b1, 1'b1, 18};
      vecs[4] = '{1'b1, 32'h24, 32'hCAFE, 32'h7777, 2,  1'b1, 1'b0, 5, 32'h0,    1'b1, 1'b0, 5};
      vecs[5] = '{1'b0, 32'h30, 32'h0,    32'h1234, 15, 1'b0, 1'b0, 0, 32'h1234, 1'b0, 1'b0, 18};
      vecs[6] = '{1'b0, 32'h34, 32'h0,    32'h9999, 16, 1'b0, 1'b0, 0, TD,       1'b1, 1'b1, 18};
      vecs[7] = '{1'b1, 32'h38, 32'h5A5A, 32'h0,    0,  1'b0, 1'b1, 2, TD,       1'b1, 1'b1, 18};

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      rsp_ready = 1'b0; s_wait = 0; s_err = 1'b0; s_hang = 1'b0; s_idle_ready = 1'b0;
      s_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_apb", {28'd0, psel, penable, pwrite, req_ready}, 32'd0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      foreach (vecs[i])
         do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].srd, vecs[i].wt, vecs[i].er,
                vecs[i].hang, vecs[i].rdly, vecs[i].e_rd, vecs[i].e_err, vecs[i].e_to,
                vecs[i].e_lat);

      // reset during ACCESS aborts the transfer without a response
      @(negedge clk);
      s_hang = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_penable", {31'd0, penable}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_apb", {29'd0, psel, penable, req_ready}, 32'd0);
      chk("abort_rsp", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0; s_hang = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_quiet", {30'd0, rsp_valid, psel}, 32'd0);
      end
      do_txn(1'b0, 32'h44, 32'h0, 32'hA5A5_0001, 1, 1'b0, 1'b0, 0, 32'hA5A5_0001, 1'b0, 1'b0, 4);

      for (int n = 0; n < 30; n++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_er   = ($urandom_range(0, 3) == 0);
         r_hang = ($urandom_range(0, 9) == 0);
         r_wt   = $urandom_range(0, 20);
         r_srd  = $urandom;
         model(r_wr, r_srd, r_wt, r_er, r_hang, m_rd, m_err, m_to, m_lat);
         do_txn(r_wr, $urandom, $urandom, r_srd, r_wt, r_er, r_hang, $urandom_range(0, 3),
                m_rd, m_err, m_to, m_lat);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
